// File: rtl/lcd_pixel_stream.sv
// RGB565 pixel FIFO feeding the LCD timing stage, frame-locked to the source's SOF marker.
// Define LCD_PIX_STATS_EN to add the saturating err_count output.
module lcd_pixel_stream #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [15:0] FILL_COLOR = 16'h0000
) (
   input  logic        PixelClk,
   input  logic        nRST,
   input  logic [15:0] s_data,
   input  logic        s_sof,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        de_in,
   input  logic        vsync_in,
   input  logic        clear_err,
   output logic        LCD_DE,
   output logic [4:0]  LCD_R,
   output logic [5:0]  LCD_G,
   output logic [4:0]  LCD_B,
   output logic        locked,
   output logic        underflow_sticky,
   output logic        align_sticky
`ifdef LCD_PIX_STATS_EN
   ,
   output logic [7:0]  err_count
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {FLUSH, SEEK, WAIT, RUN} state_t;

   state_t          state_q, state_d;
   logic [16:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wrPtr_q, rdPtr_q;
   logic [CW-1:0]   count_q;
   logic            vsync_q;
   logic            firstPop_q, firstPop_d;
   logic            de_q;
   logic [15:0]     pix_q;
   logic            underflow_q, align_q;

   logic [16:0]     headEntry;
   logic            fifoEmpty, pushReq, vsRise;
   logic            doWrite, doPop, underflowErr, alignErr;

   assign headEntry = mem_q[rdPtr_q];
   assign fifoEmpty = (count_q == '0);
   assign s_ready   = (count_q != FULL_COUNT) && (state_q != FLUSH);
   assign pushReq   = s_valid && s_ready;
   assign vsRise    = vsync_in && !vsync_q;

   // firstPop_q marks that the next pop is the one allowed to carry SOF
   always_comb begin
      state_d      = state_q;
      firstPop_d   = firstPop_q;
      doWrite      = 1'b0;
      doPop        = 1'b0;
      underflowErr = 1'b0;
      alignErr     = 1'b0;
      case (state_q)
         FLUSH: begin
            state_d    = SEEK;
            firstPop_d = 1'b0;
         end
         SEEK: begin
            if (pushReq && s_sof) begin
               doWrite = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            doWrite = pushReq;
            if (vsRise && !fifoEmpty && headEntry[16]) begin
               state_d    = RUN;
               firstPop_d = 1'b1;
            end
         end
         RUN: begin
            doWrite = pushReq;
            if (vsRise) firstPop_d = 1'b1;
            if (de_in && fifoEmpty) begin
               underflowErr = 1'b1;
            end else if (de_in) begin
               doPop      = 1'b1;
               firstPop_d = 1'b0;
               if (headEntry[16] && !(vsRise || firstPop_q)) alignErr = 1'b1;
            end
            if (vsRise && !fifoEmpty && !headEntry[16]) alignErr = 1'b1;
            if (underflowErr || alignErr) state_d = FLUSH;
            else if (vsRise && fifoEmpty) state_d = WAIT;
         end
         default: state_d = FLUSH;
      endcase
   end

   always_ff @(posedge PixelClk) begin
      if (doWrite) mem_q[wrPtr_q] <= {s_sof, s_data};
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else if (state_q == FLUSH) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doWrite) wrPtr_q <= wrPtr_q + AW'(1);
         if (doPop)   rdPtr_q <= rdPtr_q + AW'(1);
         case ({doWrite, doPop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Error set takes priority over clear_err in the same cycle
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= FLUSH;
         firstPop_q  <= 1'b0;
         vsync_q     <= 1'b0;
         de_q        <= 1'b0;
         pix_q       <= '0;
         underflow_q <= 1'b0;
         align_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         firstPop_q <= firstPop_d;
         vsync_q    <= vsync_in;
         de_q       <= de_in;
         if (!de_in)     pix_q <= '0;
         else if (doPop) pix_q <= headEntry[15:0];
         else            pix_q <= FILL_COLOR;
         if (underflowErr)   underflow_q <= 1'b1;
         else if (clear_err) underflow_q <= 1'b0;
         if (alignErr)       align_q <= 1'b1;
         else if (clear_err) align_q <= 1'b0;
      end
   end

`ifdef LCD_PIX_STATS_EN
   logic [7:0] errCount_q;

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         errCount_q <= '0;
      end else if (underflowErr || alignErr) begin
         if (errCount_q != 8'hFF) errCount_q <= errCount_q + 8'd1;
      end else if (clear_err) begin
         errCount_q <= '0;
      end
   end

   assign err_count = errCount_q;
`endif

   assign LCD_DE           = de_q;
   assign LCD_R            = pix_q[15:11];
   assign LCD_G            = pix_q[10:5];
   assign LCD_B            = pix_q[4:0];
   assign locked           = (state_q == RUN);
   assign underflow_sticky = underflow_q;
   assign align_sticky     = align_q;

endmodule
